mem_align_exception_stage: RTL and testbench



---
 rtl/mem_align_exception_stage_pkg.sv | 36 +++
 rtl/mem_align_exception_stage_align_check.sv | 26 ++
 rtl/mem_align_exception_stage.sv | 150 +++++++++++++++
 tb/tb_mem_align_exception_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_align_exception_stage_pkg.sv
// Shared definitions for the memory alignment / exception stage.
// Holds the exception codes and access byte-enable masks used by the
// cache, LSU and store buffer, plus the access-size to low-address-bit
// mask helper.
package mem_align_exception_stage_pkg;

  // Exception codes carried down the pipeline (7 bits wide).
  localparam logic [6:0] EXP_NONE = 7'h00;
  localparam logic [6:0] EXP_ALE  = 7'h09;

  // Byte-enable masks describing the access width.
  localparam logic [7:0] ACC_BYTE  = 8'h01;
  localparam logic [7:0] ACC_HALF  = 8'h03;
  localparam logic [7:0] ACC_WORD  = 8'h0F;
  localparam logic [7:0] ACC_DWORD = 8'hFF;

  // Input-blocking state after a fault has been handed downstream.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLOCK = 1'b1
  } blk_state_e;

  // Low address bits that must be zero for a naturally aligned access.
  // Unrecognised masks return 0, so they can never raise an alignment fault.
  function automatic logic [2:0] low_bit_mask(input logic [7:0] acc);
    logic [2:0] m;
    case (acc)
      ACC_HALF:  m = 3'b001;
      ACC_WORD:  m = 3'b011;
      ACC_DWORD: m = 3'b111;
      default:   m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_align_exception_stage_align_check.sv
// Combinational alignment checker: (addr, type, cacop) -> ale.
// Also used by the store buffer. A narrow type vector (MAX_BYTES=4) is
// zero-extended, so the double-word mask can never match there.
module mem_align_exception_stage_align_check
  import mem_align_exception_stage_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic [MAX_BYTES-1:0] acc_type,
  input  logic                 cacop,
  output logic                 ale
);

  logic [7:0]        type_ext;
  logic [ADDR_W-1:0] addr_mask;

  // Fault when any address bit covered by the access-size mask is set; cacops never fault.
  always_comb begin
    type_ext  = 8'(acc_type);
    addr_mask = ADDR_W'(low_bit_mask(type_ext));
    ale       = ~cacop & ((addr & addr_mask) != '0);
  end

endmodule

// File: rtl/mem_align_exception_stage.sv
// Registered pipeline stage between address generation and the data cache.
// Tags each request with its alignment exception code and bad virtual
// address, and stops accepting requests once a faulting request has been
// consumed downstream, until flush or rst.
// Optional build macro: ALE_PERF_COUNT_EN adds a saturating 32-bit
// ale_count output counting faulting requests consumed downstream.
module mem_align_exception_stage
  import mem_align_exception_stage_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [MAX_BYTES-1:0] in_type,
  input  logic                 in_cacop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [MAX_BYTES-1:0] out_type,
  output logic                 out_cacop,
  output logic [6:0]           out_exception,
  output logic [ADDR_W-1:0]    out_badv,
  output logic                 exc_blocked
`ifdef ALE_PERF_COUNT_EN
  ,
  output logic [31:0]          ale_count
`endif
);

  blk_state_e            state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
  logic [MAX_BYTES-1:0]  out_type_q, out_type_d;
  logic                  out_cacop_q, out_cacop_d;
  logic [6:0]            out_exception_q, out_exception_d;
  logic [ADDR_W-1:0]     out_badv_q, out_badv_d;

  logic in_ale;
  logic accept;
  logic out_fire;
  logic fault_consumed;

  mem_align_exception_stage_align_check #(
    .ADDR_W    (ADDR_W),
    .MAX_BYTES (MAX_BYTES)
  ) u_align_check (
    .addr     (in_addr),
    .acc_type (in_type),
    .cacop    (in_cacop),
    .ale      (in_ale)
  );

  // Handshake: accept when not blocked and the output slot is free or draining.
  always_comb begin
    in_ready       = (state_q == ST_RUN) & (~out_valid_q | out_ready);
    accept         = in_valid & in_ready;
    out_fire       = out_valid_q & out_ready;
    fault_consumed = out_fire & (out_exception_q != EXP_NONE);
  end

  // Next-state and next-payload: flush overrides the handshake and block entry.
  always_comb begin
    state_d         = state_q;
    out_valid_d     = out_valid_q;
    out_addr_d      = out_addr_q;
    out_type_d      = out_type_q;
    out_cacop_d     = out_cacop_q;
    out_exception_d = out_exception_q;
    out_badv_d      = out_badv_q;
    if (flush) begin
      // Payload is left stale; only the valid and exception tags are cleared.
      state_d         = ST_RUN;
      out_valid_d     = 1'b0;
      out_exception_d = EXP_NONE;
      out_badv_d      = '0;
    end else begin
      if (fault_consumed) begin
        state_d = ST_BLOCK;
      end
      if (accept) begin
        out_valid_d     = 1'b1;
        out_addr_d      = in_addr;
        out_type_d      = in_type;
        out_cacop_d     = in_cacop;
        out_exception_d = in_ale ? EXP_ALE : EXP_NONE;
        out_badv_d      = in_ale ? in_addr : '0;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      out_valid_q     <= 1'b0;
      out_addr_q      <= '0;
      out_type_q      <= '0;
      out_cacop_q     <= 1'b0;
      out_exception_q <= EXP_NONE;
      out_badv_q      <= '0;
    end else begin
      state_q         <= state_d;
      out_valid_q     <= out_valid_d;
      out_addr_q      <= out_addr_d;
      out_type_q      <= out_type_d;
      out_cacop_q     <= out_cacop_d;
      out_exception_q <= out_exception_d;
      out_badv_q      <= out_badv_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_addr      = out_addr_q;
  assign out_type      = out_type_q;
  assign out_cacop     = out_cacop_q;
  assign out_exception = out_exception_q;
  assign out_badv      = out_badv_q;
  assign exc_blocked   = (state_q == ST_BLOCK);

`ifdef ALE_PERF_COUNT_EN
  logic [31:0] ale_count_q, ale_count_d;

  // Saturating count of faults taken downstream; a flush-cycle consume does not count.
  always_comb begin
    ale_count_d = ale_count_q;
    if (!flush && fault_consumed && (ale_count_q != 32'hFFFF_FFFF)) begin
      ale_count_d = ale_count_q + 32'd1;
    end
  end

  // Counter register; cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      ale_count_q <= 32'd0;
    end else begin
      ale_count_q <= ale_count_d;
    end
  end

  assign ale_count = ale_count_q;
`endif

endmodule

// File: tb/tb_mem_align_exception_stage.sv
`timescale 1ns/1ps
module tb_mem_align_exception_stage;

  localparam int         AW         = 32;
  localparam logic [6:0] TB_EXP_ALE = 7'h09;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  typ;
    logic        cacop;
    logic [6:0]  exc;
    logic [31:0] badv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with MAX_BYTES=4
  logic          rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_cacop = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [3:0]    in_type = '0;
  logic          in_ready, out_valid, out_cacop, exc_blocked;
  logic [AW-1:0] out_addr, out_badv;
  logic [3:0]    out_type;
  logic [6:0]    out_exception;
  logic [31:0]   cnt4;

  // DUT with MAX_BYTES=8
  logic          f8 = 1'b0, v8 = 1'b0, c8 = 1'b0;
  logic [AW-1:0] a8 = '0;
  logic [7:0]    t8 = '0;
  logic          r8_in_ready, o8_valid, o8_cacop, o8_blocked;
  logic [AW-1:0] o8_addr, o8_badv;
  logic [7:0]    o8_type;
  logic [6:0]    o8_exc;
  logic [31:0]   cnt8;

  mem_align_exception_stage #(.ADDR_W(AW), .MAX_BYTES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_type(in_type), .in_cacop(in_cacop), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_type(out_type), .out_cacop(out_cacop),
    .out_exception(out_exception), .out_badv(out_badv), .exc_blocked(exc_blocked)
`ifdef ALE_PERF_COUNT_EN
    , .ale_count(cnt4)
`endif
  );

  mem_align_exception_stage #(.ADDR_W(AW), .MAX_BYTES(8)) dut8 (
    .clk(clk), .rst(rst), .flush(f8), .in_valid(v8), .in_ready(r8_in_ready),
    .in_addr(a8), .in_type(t8), .in_cacop(c8), .out_valid(o8_valid),
    .out_ready(1'b1), .out_addr(o8_addr), .out_type(o8_type), .out_cacop(o8_cacop),
    .out_exception(o8_exc), .out_badv(o8_badv), .exc_blocked(o8_blocked)
`ifdef ALE_PERF_COUNT_EN
    , .ale_count(cnt8)
`endif
  );

`ifndef ALE_PERF_COUNT_EN
  assign cnt4 = 32'd0;
  assign cnt8 = 32'd0;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;
  exp_t q[$];
  exp_t q8[$];

  // Reference model state (4-byte DUT)
  bit          m_ov      = 1'b0;
  bit          m_exc     = 1'b0;
  bit          m_blocked = 1'b0;
  logic [31:0] m_cnt     = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Alignment rule from access size: address must be a multiple of the size.
  function automatic bit ref_ale(input logic [31:0] a, input logic [7:0] t, input bit c, input int mb);
    int unsigned size;
    case (t)
      8'h01:   size = 1;
      8'h03:   size = 2;
      8'h0F:   size = 4;
      8'hFF:   size = (mb == 8) ? 8 : 0;
      default: size = 0;
    endcase
    if (c || size <= 1) return 1'b0;
    return (a % size) != 0;
  endfunction

  function automatic exp_t make_exp(input logic [31:0] a, input logic [7:0] t, input bit c, input int mb);
    exp_t e;
    bit   ale;
    ale     = ref_ale(a, t, c, mb);
    e.addr  = a;
    e.typ   = t;
    e.cacop = c;
    e.exc   = ale ? TB_EXP_ALE : 7'h00;
    e.badv  = ale ? a : 32'h0;
    return e;
  endfunction

  // Behavioural model: advances on each clock edge from the inputs alone.
  task automatic model_step();
    exp_t e;
    bit   rdy;
    if (rst) begin
      q.delete(); m_ov = 0; m_exc = 0; m_blocked = 0; m_cnt = 32'd0;
    end else if (flush) begin
      q.delete(); m_ov = 0; m_exc = 0; m_blocked = 0;
    end else begin
      rdy = !m_blocked && (!m_ov || out_ready);
      if (m_ov && out_ready) begin
        if (m_exc) begin
          m_blocked = 1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        m_ov = 0;
      end
      if (in_valid && rdy) begin
        e = make_exp(in_addr, 8'(in_type), in_cacop, 4);
        q.push_back(e);
        m_ov  = 1;
        m_exc = (e.exc != 7'h00);
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Monitor for the 4-byte DUT: compares each presented output against the scoreboard.
  task automatic monitor_step();
    exp_t e;
    if (!chk_en) return;
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("in_ready", 64'(in_ready), 64'(!m_blocked && (!m_ov || out_ready)));
    check("exc_blocked", 64'(exc_blocked), 64'(m_blocked));
`ifdef ALE_PERF_COUNT_EN
    check("ale_count", 64'(cnt4), 64'(m_cnt));
`endif
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_output", 64'(out_addr), 64'hDEAD_BEEF_0000_0000);
      end else begin
        e = q[0];
        check("out_addr", 64'(out_addr), 64'(e.addr));
        check("out_type", 64'(out_type), 64'(e.typ[3:0]));
        check("out_cacop", 64'(out_cacop), 64'(e.cacop));
        check("out_exception", 64'(out_exception), 64'(e.exc));
        check("out_badv", 64'(out_badv), 64'(e.badv));
        if (out_ready) void'(q.pop_front());
      end
    end
  endtask

  always @(negedge clk) monitor_step();

  // Monitor for the 8-byte DUT (out_ready tied high, so every output is consumed).
  task automatic monitor8_step();
    exp_t e;
    if (!chk_en) return;
    if (o8_valid === 1'b1) begin
      if (q8.size() == 0) begin
        check("u8_unexpected_output", 64'(o8_addr), 64'hDEAD_BEEF_0000_0000);
      end else begin
        e = q8.pop_front();
        check("u8_out_addr", 64'(o8_addr), 64'(e.addr));
        check("u8_out_type", 64'(o8_type), 64'(e.typ));
        check("u8_out_exception", 64'(o8_exc), 64'(e.exc));
        check("u8_out_badv", 64'(o8_badv), 64'(e.badv));
      end
    end
  endtask

  always @(negedge clk) monitor8_step();

  // Present one cycle of inputs to the 4-byte DUT; returns 1ns after the edge.
  task automatic drive(input bit v, input logic [31:0] a, input logic [3:0] t, input bit c,
                       input bit r, input bit f);
    in_valid = v; in_addr = a; in_type = t; in_cacop = c; out_ready = r; flush = f;
    @(posedge clk); #1;
  endtask

  // One request into the 8-byte DUT, followed by a flush cycle to clear any block.
  task automatic issue8(input logic [31:0] a, input logic [7:0] t, input bit c);
    check("u8_in_ready", 64'(r8_in_ready), 64'd1);
    v8 = 1; a8 = a; t8 = t; c8 = c; f8 = 0;
    q8.push_back(make_exp(a, t, c, 8));
    @(posedge clk); #1;
    v8 = 0; f8 = 1;
    @(posedge clk); #1;
    f8 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rt;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_type", 64'(out_type), 64'd0);
    check("rst_out_cacop", 64'(out_cacop), 64'd0);
    check("rst_out_exception", 64'(out_exception), 64'd0);
    check("rst_out_badv", 64'(out_badv), 64'd0);
    check("rst_exc_blocked", 64'(exc_blocked), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_u8_out_valid", 64'(o8_valid), 64'd0);
    @(posedge clk); #1;
    chk_en = 1;

    // Misaligned word, consumed immediately -> block
    drive(1, 32'h1000_0002, 4'hF, 0, 1, 0);
    drive(0, 32'h0, 4'h0, 0, 1, 0);
    check("blocked_after_ale", 64'({exc_blocked, in_ready}), 64'b10);
    drive(1, 32'h0000_0010, 4'hF, 0, 1, 0);
    drive(1, 32'h0000_0020, 4'hF, 0, 1, 1);
    check("flush_release", 64'({in_ready, out_valid}), 64'b10);

    // Misaligned half as cacop: no exception, no block
    drive(1, 32'h0000_0003, 4'h3, 1, 1, 0);
    drive(0, 32'h0, 4'h0, 0, 1, 0);
    check("cacop_no_block", 64'(exc_blocked), 64'd0);

    // Back-to-back aligned words
    for (int i = 0; i < 8; i++) drive(1, 32'h100 + 32'(4 * i), 4'hF, 0, 1, 0);
    drive(0, 32'h0, 4'h0, 0, 1, 0);

    // Faulting word stalled for 3 cycles, then released, then flushed
    drive(1, 32'h0000_2001, 4'hF, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 32'h0000_3000, 4'hF, 0, 0, 0);
    drive(0, 32'h0, 4'h0, 0, 1, 0);
    drive(1, 32'h0000_3004, 4'hF, 0, 1, 0);
    drive(1, 32'h0000_3008, 4'hF, 0, 1, 1);
    check("stall_flush_release", 64'({in_ready, out_valid}), 64'b10);

    // Fault consumed in the same cycle as flush: stays RUN
    drive(1, 32'h0000_5001, 4'h3, 0, 1, 0);
    drive(0, 32'h0, 4'h0, 0, 1, 1);
    check("flush_beats_block", 64'({exc_blocked, in_ready}), 64'b01);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: rt = 4'h1;
        1: rt = 4'h3;
        2: rt = 4'hF;
        3: rt = 4'h5;
        default: rt = 4'($urandom);
      endcase
      drive(($urandom % 4) != 0, $urandom, rt, ($urandom % 5) == 0,
            ($urandom % 4) != 0, ($urandom % 25) == 0);
    end
    drive(0, 32'h0, 4'h0, 0, 1, 1);

    // Reset while blocked with a request still held
    drive(1, 32'h0000_4002, 4'hF, 0, 1, 0);
    drive(1, 32'h0000_4004, 4'hF, 0, 1, 0);
    drive(0, 32'h0, 4'h0, 0, 0, 0);
    check("pre_rst_state", 64'({exc_blocked, out_valid}), 64'b11);
    rst = 1;
    drive(0, 32'h0, 4'h0, 0, 0, 0);
    rst = 0;
    check("rst2_out_valid", 64'(out_valid), 64'd0);
    check("rst2_out_addr", 64'(out_addr), 64'd0);
    check("rst2_out_exception", 64'(out_exception), 64'd0);
    check("rst2_out_badv", 64'(out_badv), 64'd0);
    check("rst2_exc_blocked", 64'(exc_blocked), 64'd0);

    // Three faults taken downstream, each followed by a flush
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0000_6001 + 32'(16 * i), 4'hF, 0, 1, 0);
      drive(0, 32'h0, 4'h0, 0, 1, 0);
      drive(0, 32'h0, 4'h0, 0, 1, 1);
    end
`ifdef ALE_PERF_COUNT_EN
    check("ale_count_3", 64'(cnt4), 64'd3);
`endif

    // 8-byte instance: doubles and odd masks
    issue8(32'h8000_0004, 8'hFF, 0);
    issue8(32'h8000_0008, 8'hFF, 0);
    issue8(32'h8000_0001, 8'h05, 0);
    issue8(32'h8000_0006, 8'h0F, 0);
    issue8(32'h8000_0004, 8'hFF, 1);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: issue8($urandom, 8'h01, ($urandom % 5) == 0);
        1: issue8($urandom, 8'h03, ($urandom % 5) == 0);
        2: issue8($urandom, 8'h0F, ($urandom % 5) == 0);
        3: issue8($urandom, 8'hFF, ($urandom % 5) == 0);
        default: issue8($urandom, 8'($urandom), 0);
      endcase
    end

    // Drain and confirm nothing expected is still outstanding
    for (int i = 0; i < 3; i++) drive(0, 32'h0, 4'h0, 0, 1, 0);
    check("drain_q", 64'(q.size()), 64'd0);
    check("drain_q8", 64'(q8.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
